dma_burst_gen: RTL and testbench

DMA_BURST_GEN -- requirements
Module: dma_burst_gen

---
 rtl/dma_burst_gen.sv | 181 ++++++++++++++++++
 tb/tb_dma_burst_gen.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_burst_gen.sv
// dma_burst_gen: splits a DMA job (start address, length) into AXI INCR write
// address bursts that never cross a MAX_BL-beat or 4 KB boundary. It bounds the
// number of bursts awaiting B responses and records response errors.
// Latency: first burst is presented the cycle after job acceptance; addr/len
// update on every AW handshake.
// Backpressure: axvalid holds axaddr/axlen stable until axready; new bursts are
// stalled while OST_MAX bursts are outstanding.
// Optional feature macro: DMA_TIMEOUT_EN (progress watchdog, sets dma_err[3]).
// Ports: clk/reset_n; job handshake dma_valid/dma_ready with dma_sa/dma_len;
// dma_irq (DONE) / dma_irq_w1c; dma_err; AW channel ax*; B snoop usr_b*.
module dma_burst_gen #(
  parameter int AXI_DW  = 128,
  parameter int AXI_AW  = 32,
  parameter int AXI_IW  = 8,
  parameter int AXI_LW  = 8,
  parameter int AXID    = 1,
  parameter int MAX_BL  = 16,
  parameter int OST_MAX = 4,
  parameter int TO_CYC  = 65535
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              dma_valid,
  output logic              dma_ready,
  input  logic [31:0]       dma_sa,
  input  logic [31:0]       dma_len,
  input  logic              dma_irq_w1c,
  output logic              dma_irq,
  output logic [3:0]        dma_err,
  output logic [AXI_IW-1:0] axid,
  output logic [AXI_AW-1:0] axaddr,
  output logic [AXI_LW-1:0] axlen,
  output logic [2:0]        axsize,
  output logic [1:0]        axburst,
  output logic              axvalid,
  input  logic              axready,
  input  logic [AXI_IW-1:0] usr_bid,
  input  logic [1:0]        usr_bresp,
  input  logic              usr_bvalid,
  input  logic              usr_bready
);

  localparam int L  = $clog2(AXI_DW / 8);
  localparam int BL = $clog2(MAX_BL);
  localparam int WW = 32 - L;  // word-address / word-length width
  localparam int OW = 8;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, DONE} state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] addr_q, addr_d;
  logic [WW-1:0] len_q, len_d;
  logic [OW-1:0] ost_q, ost_d;
  logic [3:0]    err_q, err_d;

  logic          ax_hs, b_hs, b_cnt, last_burst;
  logic [WW:0]   room, len_x, beats;
  logic [31:0]   byte_addr;

  // Sub-word address/length bits are intentionally ignored.
  logic unused_low_bits;
  assign unused_low_bits = ^{dma_sa[L-1:0], dma_len[L-1:0]};

  assign ax_hs = axvalid && axready;
  assign b_hs  = usr_bvalid && usr_bready;
  // Responses with nothing outstanding never decrement the counter.
  assign b_cnt = b_hs && (ost_q != '0);

  // Beats left before the next MAX_BL-aligned boundary; since
  // MAX_BL*AXI_DW/8 <= 4096 this also keeps bursts inside a 4 KB page.
  assign room       = (WW+1)'(MAX_BL) - (WW+1)'(addr_q[BL-1:0]);
  assign len_x      = {1'b0, len_q};
  assign beats      = (len_x < room) ? len_x : room;
  assign last_burst = ax_hs && (len_x <= room);

  assign byte_addr = {addr_q, {L{1'b0}}};
  assign axaddr    = byte_addr[AXI_AW-1:0];
  assign axlen     = AXI_LW'(beats - (WW+1)'(1));
  assign axsize    = 3'(L);
  assign axburst   = 2'b01;
  assign axid      = AXI_IW'(AXID);
  assign dma_err   = err_q;

`ifdef DMA_TIMEOUT_EN
  // Watchdog: counts cycles without AW/B progress while a job is in flight.
  logic [31:0] to_q, to_d;
  logic        to_active, to_fire;

  always_comb begin
    to_active = (state_q == BUSY) || (state_q == RESP);
    to_fire   = to_active && !ax_hs && !b_hs && ((to_q + 32'd1) == 32'(TO_CYC));
    to_d      = (to_active && !ax_hs && !b_hs) ? to_q + 32'd1 : '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) to_q <= '0;
    else          to_q <= to_d;
  end
`else
  logic to_fire;
  assign to_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (dma_valid && (dma_len[31:L] != '0)) state_d = BUSY;
      BUSY: begin
        if (to_fire)         state_d = DONE;
        else if (last_burst) state_d = (ost_d != '0) ? RESP : DONE;
      end
      RESP: if (to_fire || (ost_d == '0)) state_d = DONE;
      DONE: if (dma_irq_w1c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    dma_ready = 1'b0;
    dma_irq   = 1'b0;
    axvalid   = 1'b0;
    case (state_q)
      IDLE:    dma_ready = 1'b1;
      BUSY:    axvalid   = (ost_q < OW'(OST_MAX));
      DONE:    dma_irq   = 1'b1;
      default: ;
    endcase
  end

  // Datapath: address/length/outstanding/error
  always_comb begin
    addr_d = addr_q;
    len_d  = len_q;
    err_d  = err_q;
    ost_d  = ost_q + OW'(ax_hs) - OW'(b_cnt);

    if (state_q == IDLE && state_d == BUSY) begin
      addr_d = dma_sa[31:L];
      len_d  = dma_len[31:L];
    end else if (ax_hs) begin
      addr_d = addr_q + beats[WW-1:0];
      len_d  = len_q - beats[WW-1:0];
    end

`ifdef DMA_TIMEOUT_EN
    // Bursts abandoned by a timeout may never be answered.
    if (state_q == DONE && dma_irq_w1c) ost_d = '0;
`endif

    if (state_q == DONE && dma_irq_w1c) begin
      err_d = '0;
    end else begin
      if (b_hs && (err_q[1:0] == 2'b00)) err_d[1:0] = usr_bresp;
      if (b_hs && (usr_bid != AXI_IW'(AXID))) err_d[2] = 1'b1;
      if (to_fire) err_d[3] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      len_q  <= '0;
      ost_q  <= '0;
      err_q  <= '0;
    end else begin
      addr_q <= addr_d;
      len_q  <= len_d;
      ost_q  <= ost_d;
      err_q  <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_burst_gen.sv
module tb_dma_burst_gen;
  localparam int OST = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        dma_valid, dma_ready, dma_irq_w1c, dma_irq;
  logic [31:0] dma_sa, dma_len;
  logic [3:0]  dma_err;
  logic [7:0]  axid, axlen, usr_bid;
  logic [31:0] axaddr;
  logic [2:0]  axsize;
  logic [1:0]  axburst, usr_bresp;
  logic        axvalid, axready, usr_bvalid, usr_bready;

  dma_burst_gen #(
    .AXI_DW(128), .AXI_AW(32), .AXI_IW(8), .AXI_LW(8), .AXID(1),
    .MAX_BL(16), .OST_MAX(OST), .TO_CYC(100)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .dma_valid(dma_valid), .dma_ready(dma_ready),
    .dma_sa(dma_sa), .dma_len(dma_len),
    .dma_irq_w1c(dma_irq_w1c), .dma_irq(dma_irq), .dma_err(dma_err),
    .axid(axid), .axaddr(axaddr), .axlen(axlen), .axsize(axsize),
    .axburst(axburst), .axvalid(axvalid), .axready(axready),
    .usr_bid(usr_bid), .usr_bresp(usr_bresp),
    .usr_bvalid(usr_bvalid), .usr_bready(usr_bready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] a; logic [7:0] l; } burst_t;
  typedef struct packed { logic [31:0] sa; logic [31:0] len; } job_t;

  burst_t     exp_q[$];
  job_t       job_q[$];
  int         ost_m = 0;
  logic [3:0] err_m = '0;
  int         n_cmp = 0, n_bad = 0;
  bit         mon_en = 1'b0;
  bit         b_auto = 1'b1;
  int         b_force = 0;
  int         b_pct = 100, ar_pct = 100;
  logic [7:0] b_id_drv = 8'd1;
  logic [1:0] b_resp_drv = 2'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: split a job into bursts from the boundary rules alone.
  function automatic void expand(input logic [31:0] sa, input logic [31:0] len);
    longint wa, wl, room, n;
    burst_t b;
    wa = longint'(sa >> 4);
    wl = longint'(len >> 4);
    while (wl > 0) begin
      room = 16 - (wa % 16);
      n    = (wl < room) ? wl : room;
      b.a  = 32'(wa << 4);
      b.l  = 8'(n - 1);
      exp_q.push_back(b);
      wa = (wa + n) % (longint'(1) << 28);
      wl = wl - n;
    end
  endfunction

  // Monitor / scoreboard, sampled on the falling edge.
  always @(negedge clk) begin : mon
    bit     ev, dec;
    burst_t b;
    job_t   j;
    if (reset_n && mon_en) begin
      ev = (exp_q.size() > 0) && (ost_m < OST);
      chk("axvalid", {63'd0, axvalid}, {63'd0, ev});
      if (axvalid && axready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_burst", 64'd1, 64'd0);
        end else begin
          b = exp_q.pop_front();
          chk("axaddr", {32'd0, axaddr}, {32'd0, b.a});
          chk("axlen", {56'd0, axlen}, {56'd0, b.l});
          chk("axsize_axburst_axid", {51'd0, axsize, axburst, axid}, {51'd0, 3'd4, 2'd1, 8'd1});
        end
      end
      dec = usr_bvalid && usr_bready && (ost_m > 0);
      if (usr_bvalid && usr_bready) begin
        if (err_m[1:0] == 2'b00) err_m[1:0] = usr_bresp;
        if (usr_bid != 8'd1) err_m[2] = 1'b1;
      end
      ost_m = ost_m + int'(axvalid && axready) - int'(dec);
      if (dma_valid && dma_ready && job_q.size() > 0) begin
        j = job_q.pop_front();
        expand(j.sa, j.len);
      end
    end
  end

  // B responder: single-cycle pulses while bursts are outstanding.
  always @(posedge clk) begin
    #1;
    if (!reset_n || usr_bvalid) begin
      usr_bvalid = 1'b0;
    end else if (ost_m > 0 && (b_force > 0 || (b_auto && $urandom_range(99) < b_pct))) begin
      usr_bvalid = 1'b1;
      usr_bid    = b_id_drv;
      usr_bresp  = b_resp_drv;
      if (b_force > 0) b_force--;
    end
  end

  always @(posedge clk) begin
    #1;
    axready = ($urandom_range(99) < ar_pct);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_job(input logic [31:0] sa, input logic [31:0] len);
    int i;
    job_t j;
    for (i = 0; i < 50 && !dma_ready; i++) tick(1);
    chk("ready_for_job", {63'd0, dma_ready}, 64'd1);
    j.sa = sa;
    j.len = len;
    job_q.push_back(j);
    dma_valid = 1'b1;
    dma_sa    = sa;
    dma_len   = len;
    tick(1);
    dma_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit check_empty, output int cyc);
    cyc = 0;
    while (cyc < budget && !dma_irq) begin
      tick(1);
      cyc++;
    end
    chk("irq_reached", {63'd0, dma_irq}, 64'd1);
    if (check_empty) begin
      chk("bursts_left", 64'(exp_q.size()), 64'd0);
      chk("ost_at_done", 64'(ost_m), 64'd0);
    end
  endtask

  task automatic clear_done();
    chk("err_at_done", {60'd0, dma_err}, {60'd0, err_m});
    dma_irq_w1c = 1'b1;
    tick(1);
    dma_irq_w1c = 1'b0;
    err_m = '0;
`ifdef DMA_TIMEOUT_EN
    ost_m = 0;
`endif
    chk("ready_after_w1c", {63'd0, dma_ready}, 64'd1);
    chk("err_after_w1c", {60'd0, dma_err}, 64'd0);
    chk("irq_after_w1c", {63'd0, dma_irq}, 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual=running required=done");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] sa, len;
    reset_n = 1'b0;
    dma_valid = 1'b0; dma_sa = '0; dma_len = '0; dma_irq_w1c = 1'b0;
    axready = 1'b0; usr_bvalid = 1'b0; usr_bready = 1'b1;
    usr_bid = 8'd1; usr_bresp = 2'd0;
    tick(3);
    chk("rst_ready", {63'd0, dma_ready}, 64'd1);
    chk("rst_axvalid", {63'd0, axvalid}, 64'd0);
    chk("rst_irq", {63'd0, dma_irq}, 64'd0);
    chk("rst_err", {60'd0, dma_err}, 64'd0);
    chk("rst_axaddr", {32'd0, axaddr}, 64'd0);
    reset_n = 1'b1;
    mon_en = 1'b1;
    tick(2);

    // Aligned 1 KB job, always-ready slave.
    run_job(32'h1000, 32'h400);
    wait_done(500, 1'b1, cyc);
    clear_done();

    // Start just below a 4 KB page.
    run_job(32'h0FF0, 32'h30);
    wait_done(500, 1'b1, cyc);
    clear_done();

    // Withheld responses: issue stalls at OST, one B releases one burst.
    b_auto = 1'b0;
    run_job(32'h2000, 32'h400);
    tick(10);
    chk("ost_stall", 64'(ost_m), 64'd2);
    chk("left_stall", 64'(exp_q.size()), 64'd2);
    b_force = 1;
    tick(10);
    chk("ost_after_one_b", 64'(ost_m), 64'd2);
    chk("left_after_one_b", 64'(exp_q.size()), 64'd1);
    b_auto = 1'b1;
    wait_done(500, 1'b1, cyc);
    clear_done();

    // Error responses; w1c mid-job must not clear errors.
    b_id_drv = 8'd3;
    b_resp_drv = 2'd2;
    run_job(32'h3000, 32'h400);
    tick(2);
    dma_irq_w1c = 1'b1;
    tick(1);
    dma_irq_w1c = 1'b0;
    wait_done(500, 1'b1, cyc);
    tick(3);
    chk("err_hold", {60'd0, dma_err}, 64'h6);
    clear_done();
    b_id_drv = 8'd1;
    b_resp_drv = 2'd0;

    // Sub-word length: accepted and dropped.
    run_job(32'h0100, 32'h8);
    tick(4);
    chk("zero_len_ready", {63'd0, dma_ready}, 64'd1);
    chk("zero_len_irq", {63'd0, dma_irq}, 64'd0);

    // Reset in the middle of a job.
    b_auto = 1'b0;
    run_job(32'h4000, 32'h400);
    tick(4);
    reset_n = 1'b0;
    #1;
    chk("midrst_axvalid", {63'd0, axvalid}, 64'd0);
    chk("midrst_ready", {63'd0, dma_ready}, 64'd1);
    chk("midrst_axaddr", {32'd0, axaddr}, 64'd0);
    exp_q.delete();
    job_q.delete();
    ost_m = 0;
    err_m = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk("postrst_axvalid", {63'd0, axvalid}, 64'd0);
    chk("postrst_ready", {63'd0, dma_ready}, 64'd1);
    b_auto = 1'b1;

`ifdef DMA_TIMEOUT_EN
    // No responses at all: watchdog ends the job.
    b_auto = 1'b0;
    run_job(32'h5000, 32'h400);
    cyc = 0;
    while (cyc < 20 && ost_m != 2) begin
      tick(1);
      cyc++;
    end
    wait_done(300, 1'b0, cyc);
    chk("timeout_window", {63'd0, (cyc >= 95 && cyc <= 105)}, 64'd1);
    err_m[3] = 1'b1;
    chk("timeout_err3", {63'd0, dma_err[3]}, 64'd1);
    exp_q.delete();
    clear_done();
    b_auto = 1'b1;
`endif

    // Randomized jobs.
    for (int k = 0; k < 15; k++) begin
      sa = $urandom;
      len = $urandom_range(32'h600, 0);
      b_pct = $urandom_range(100, 20);
      ar_pct = $urandom_range(100, 30);
      b_resp_drv = ($urandom_range(9) == 0) ? 2'($urandom_range(3, 1)) : 2'd0;
      b_id_drv = ($urandom_range(9) == 0) ? 8'd5 : 8'd1;
      run_job(sa, len);
      if (len[31:4] == '0) begin
        tick(3);
        chk("rand_zero_ready", {63'd0, dma_ready}, 64'd1);
      end else begin
        wait_done(3000, 1'b1, cyc);
        clear_done();
      end
    end

    tick(5);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
